tlb_refill_walker: RTL and testbench

- Fills the processor's translation lookaside buffer (TLB) after a lookup miss, so it is the writer for the TLB's read-only lookup path.
- On a miss it reads the page table entry (PTE) for the missing virtual page from memory, at page-table base register (PTBR) + virtual page number (VPN).
- If the PTE is valid, it writes the translation into a round-robin victim slot and signals done. If not, it signals a page fault.
- Sits between the TLB, the memory port and the control unit, which stalls while a refill is in progress.

---
 rtl/tlb_pkg.sv | 28 ++
 rtl/tlb_victim_ptr.sv | 38 +++
 rtl/tlb_refill_walker.sv | 206 ++++++++++++++++++++
 tb/tb_tlb_refill_walker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB refill walker.
//   - address / page / TLB geometry
//   - PTE bit positions
//   - walker state encoding
package tlb_pkg;

    localparam int VA_W     = 16;
    localparam int OFFSET_W = 6;
    localparam int VPN_W    = VA_W - OFFSET_W;
    localparam int PPN_W    = 10;
    localparam int ENTRIES  = 50;
    localparam int IDX_W    = 6;
    localparam int PTE_W    = 16;

    localparam int PTE_V = 15;
    localparam int PTE_D = 14;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        REQ,
        WAIT,
        CHECK,
        FILL,
        DONE
    } walk_state_e;

endpackage

// File: rtl/tlb_victim_ptr.sv
// tlb_victim_ptr: round-robin TLB victim slot pointer.
//   clk_i  in   clock
//   rst_i  in   async active-high reset, pointer -> 0
//   inc_i  in   advance to the next slot
//   ptr_o  out  current victim slot, wraps N_ENTRIES-1 -> 0
module tlb_victim_ptr
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = ENTRIES,
    parameter int W         = IDX_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == W'(N_ENTRIES - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: fills a TLB slot after a lookup miss by reading the PTE
// at ptbr + vpn. A valid PTE is written into the round-robin victim slot and
// done pulses; an invalid PTE pulses fault instead.
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   miss_valid_i/miss_vpn_i      miss request and missing virtual page
//   miss_ready_o                 walker idle (request taken on valid&&ready)
//   ptbr_i                       page-table base address
//   mem_req_o/mem_addr_o         memory request, held until mem_gnt_i
//   mem_rvalid_i/mem_rdata_i     PTE read return ([15] valid, [14] dirty, PPN)
//   tlb_we_o/tlb_idx_o/...       TLB write port (idx always shows victim)
//   victim_*_i                   current victim slot contents (write-back only)
//   mem_we_o/mem_wdata_o         write qualifier / data (write-back only)
//   done_o, fault_o              one-cycle completion / page-fault pulses
//
// Build option: TLB_DIRTY_WRITEBACK_EN writes a dirty victim's PTE back to
// memory (state WB_REQ) before the refill read. Without it the victim_*
// inputs are ignored and mem_we_o/mem_wdata_o are tied low.
//
// State    | meaning
// IDLE     | ready for a miss
// WB_REQ   | writing the dirty victim PTE back (option only)
// REQ      | PTE read requested, waiting for grant
// WAIT     | waiting for read data
// CHECK    | PTE valid check, fault pulse on invalid
// FILL     | TLB write strobe
// DONE     | done pulse
module tlb_refill_walker
    import tlb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             miss_valid_i,
    input  logic [VPN_W-1:0] miss_vpn_i,
    output logic             miss_ready_o,
    input  logic [VA_W-1:0]  ptbr_i,
    output logic             mem_req_o,
    output logic [VA_W-1:0]  mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [PTE_W-1:0] mem_rdata_i,
    output logic             tlb_we_o,
    output logic [IDX_W-1:0] tlb_idx_o,
    output logic [VPN_W-1:0] tlb_vpn_o,
    output logic [PPN_W-1:0] tlb_ppn_o,
    output logic             tlb_dirty_o,
    input  logic             victim_dirty_i,
    input  logic [VPN_W-1:0] victim_vpn_i,
    input  logic [PPN_W-1:0] victim_ppn_i,
    output logic             mem_we_o,
    output logic [PTE_W-1:0] mem_wdata_o,
    output logic             done_o,
    output logic             fault_o
);

    walk_state_e      state_q;
    logic             miss_ready_q;
    logic             mem_req_q;
    logic [VA_W-1:0]  addr_q;
    logic [VPN_W-1:0] vpn_q;
    logic [PTE_W-1:0] pte_q;
    logic             tlb_we_q;
    logic             done_q;
    logic             fault_q;
    logic [VA_W-1:0]  pte_addr;

    assign pte_addr = ptbr_i + {{(VA_W-VPN_W){1'b0}}, miss_vpn_i};

`ifdef TLB_DIRTY_WRITEBACK_EN
    logic             mem_we_q;
    logic [PTE_W-1:0] wdata_q;
    logic [VA_W-1:0]  pte_addr_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            miss_ready_q <= 1'b1;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            vpn_q        <= '0;
            pte_q        <= '0;
            tlb_we_q     <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
`ifdef TLB_DIRTY_WRITEBACK_EN
            mem_we_q     <= 1'b0;
            wdata_q      <= '0;
            pte_addr_q   <= '0;
`endif
        end else begin
            // single-cycle pulses
            tlb_we_q <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid_i) begin
                        vpn_q        <= miss_vpn_i;
                        miss_ready_q <= 1'b0;
                        mem_req_q    <= 1'b1;
`ifdef TLB_DIRTY_WRITEBACK_EN
                        if (victim_dirty_i) begin
                            state_q    <= WB_REQ;
                            mem_we_q   <= 1'b1;
                            addr_q     <= ptbr_i + {{(VA_W-VPN_W){1'b0}}, victim_vpn_i};
                            wdata_q    <= {1'b1, 1'b0, {(PTE_W-2-PPN_W){1'b0}}, victim_ppn_i};
                            pte_addr_q <= pte_addr;
                        end else begin
                            state_q <= REQ;
                            addr_q  <= pte_addr;
                        end
`else
                        state_q <= REQ;
                        addr_q  <= pte_addr;
`endif
                    end
                end
`ifdef TLB_DIRTY_WRITEBACK_EN
                WB_REQ: begin
                    // mem_req stays high straight into the PTE read
                    if (mem_gnt_i) begin
                        state_q  <= REQ;
                        mem_we_q <= 1'b0;
                        wdata_q  <= '0;
                        addr_q   <= pte_addr_q;
                    end
                end
`endif
                REQ: begin
                    if (mem_gnt_i) begin
                        state_q   <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // fault is decided here so the pulse lines up with CHECK
                    if (mem_rvalid_i) begin
                        pte_q   <= mem_rdata_i;
                        fault_q <= ~mem_rdata_i[PTE_V];
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (pte_q[PTE_V]) begin
                        state_q  <= FILL;
                        tlb_we_q <= 1'b1;
                    end else begin
                        state_q      <= IDLE;
                        miss_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q      <= IDLE;
                    miss_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    miss_ready_q <= 1'b1;
                    mem_req_q    <= 1'b0;
                end
            endcase
        end
    end

    tlb_victim_ptr #(
        .N_ENTRIES (ENTRIES),
        .W         (IDX_W)
    ) u_victim_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (state_q == FILL),
        .ptr_o (tlb_idx_o)
    );

    assign miss_ready_o = miss_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign tlb_we_o     = tlb_we_q;
    assign tlb_vpn_o    = vpn_q;
    assign tlb_ppn_o    = pte_q[PPN_W-1:0];
    assign tlb_dirty_o  = pte_q[PTE_D];
    assign done_o       = done_q;
    assign fault_o      = fault_q;

    // PTE bits between the dirty flag and the PPN carry nothing here
    logic unused_pte;
    assign unused_pte = ^pte_q[PTE_D-1:PPN_W];

`ifdef TLB_DIRTY_WRITEBACK_EN
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = wdata_q;
`else
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;

    logic unused_victim;
    assign unused_victim = ^{victim_dirty_i, victim_vpn_i, victim_ppn_i};
`endif

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker: each refill pushes its expected
// memory / TLB / done / fault events, a negedge monitor pops and compares.
module tb_tlb_refill_walker;
    import tlb_pkg::*;

    localparam int K_RD    = 0;
    localparam int K_WR    = 1;
    localparam int K_TLB   = 2;
    localparam int K_DONE  = 3;
    localparam int K_FAULT = 4;

    typedef struct {
        int               kind;
        logic [15:0]      addr;
        logic [15:0]      wdata;
        logic [IDX_W-1:0] idx;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        logic             dirty;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             miss_valid = 1'b0;
    logic [VPN_W-1:0] miss_vpn = '0;
    logic             miss_ready;
    logic [15:0]      ptbr = 16'h0100;
    logic             mem_req;
    logic [15:0]      mem_addr;
    logic             mem_gnt = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic [15:0]      mem_rdata = '0;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_idx;
    logic [VPN_W-1:0] tlb_vpn;
    logic [PPN_W-1:0] tlb_ppn;
    logic             tlb_dirty;
    logic             victim_dirty = 1'b0;
    logic [VPN_W-1:0] victim_vpn = 10'd7;
    logic [PPN_W-1:0] victim_ppn = 10'h011;
    logic             mem_we;
    logic [15:0]      mem_wdata;
    logic             done;
    logic             fault;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;

    tlb_refill_walker dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .miss_valid_i   (miss_valid),
        .miss_vpn_i     (miss_vpn),
        .miss_ready_o   (miss_ready),
        .ptbr_i         (ptbr),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .tlb_we_o       (tlb_we),
        .tlb_idx_o      (tlb_idx),
        .tlb_vpn_o      (tlb_vpn),
        .tlb_ppn_o      (tlb_ppn),
        .tlb_dirty_o    (tlb_dirty),
        .victim_dirty_i (victim_dirty),
        .victim_vpn_i   (victim_vpn),
        .victim_ppn_i   (victim_ppn),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .done_o         (done),
        .fault_o        (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        bit   ok;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, want no event", kind);
            return;
        end
        e  = sb.pop_front();
        ok = (kind == e.kind);
        case (kind)
            K_RD:  ok = ok && (mem_addr === e.addr);
            K_WR:  ok = ok && (mem_addr === e.addr) && (mem_wdata === e.wdata);
            K_TLB: ok = ok && (tlb_idx === e.idx) && (tlb_vpn === e.vpn) &&
                        (tlb_ppn === e.ppn) && (tlb_dirty === e.dirty);
            default: ;
        endcase
        if (!ok) begin
            n_bad++;
            $display("FAIL event: got kind=%0d addr=%h wdata=%h idx=%0d vpn=%h ppn=%h d=%b, want kind=%0d addr=%h wdata=%h idx=%0d vpn=%h ppn=%h d=%b",
                     kind, mem_addr, mem_wdata, tlb_idx, tlb_vpn, tlb_ppn, tlb_dirty,
                     e.kind, e.addr, e.wdata, e.idx, e.vpn, e.ppn, e.dirty);
        end
    endtask

    // monitor: every DUT output event must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_gnt) check_evt(mem_we ? K_WR : K_RD);
            if (tlb_we) check_evt(K_TLB);
            if (done)   check_evt(K_DONE);
            if (fault)  check_evt(K_FAULT);
        end
    end

    // One complete miss. g / r: cycles from entering REQ / WAIT until the
    // grant / read-data cycle (1 = immediate). hold keeps a second miss
    // (next_vpn) pending across the walk. wb: victim is dirty on accept.
    task automatic do_refill(input logic [VPN_W-1:0] vpn, input logic [15:0] rdata,
                             input int g, input int r, input logic [IDX_W-1:0] idx,
                             input bit hold, input logic [VPN_W-1:0] next_vpn, input bit wb);
        logic [15:0] addr;
        int unsigned acc;
        int          base;
        int          n;
        exp_t        e;
        addr = ptbr + {6'b0, vpn};
        e    = '{default: 0};
        if (wb) begin
            e.kind  = K_WR;
            e.addr  = ptbr + {6'b0, victim_vpn};
            e.wdata = {6'b100000, victim_ppn};
            sb.push_back(e);
        end
        e.kind = K_RD;
        e.addr = addr;
        sb.push_back(e);
        if (rdata[15]) begin
            e.kind  = K_TLB;
            e.idx   = idx;
            e.vpn   = vpn;
            e.ppn   = rdata[9:0];
            e.dirty = rdata[14];
            sb.push_back(e);
            e.kind = K_DONE;
            sb.push_back(e);
            base = 5;
        end else begin
            e.kind = K_FAULT;
            sb.push_back(e);
            base = 3;
        end
        if (wb) base++;

        chk("miss_ready_idle", miss_ready, 1);
        miss_valid = 1'b1;
        miss_vpn   = vpn;
        if (wb) victim_dirty = 1'b1;
        tick();
        acc          = cyc;
        victim_dirty = 1'b0;
        if (hold) miss_vpn = next_vpn;
        else miss_valid = 1'b0;

        if (wb) begin
            chk("wb_mem_we", mem_we, 1);
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
        end
        repeat (g - 1) begin
            chk("req_held", mem_req, 1);
            chk("req_addr_stable", mem_addr, addr);
            if (hold) chk("busy_not_ready", miss_ready, 0);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (r - 1) begin
            chk("req_dropped", mem_req, 0);
            if (hold) chk("busy_not_ready", miss_ready, 0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;

        n = 0;
        while (!(done || fault) && n < 12) begin
            tick();
            n++;
        end
        if (!(done || fault)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL completion_timeout: got no done/fault in 12 cycles, want one");
        end else begin
            chk("latency", cyc - acc + 1, base + (g - 1) + (r - 1));
        end
        tick();
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_tlb_we", tlb_we, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_tlb_idx", tlb_idx, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick();

        // invalid PTE: fault, victim pointer untouched
        do_refill(10'd9, 16'h0023, 1, 1, 6'd0, 1'b0, '0, 1'b0);
        chk("idx_after_fault", tlb_idx, 0);
        // basic refill: addr 0x0105, slot 0, ppn 0x023, clean
        do_refill(10'd5, 16'h8023, 1, 1, 6'd0, 1'b0, '0, 1'b0);
        // address wrap 0xFF00+0x3FF -> 0x02FF, dirty PTE
        ptbr = 16'hFF00;
        do_refill(10'h3FF, 16'hC3FF, 1, 1, 6'd1, 1'b0, '0, 1'b0);
        ptbr = 16'h0100;
        // slow grant / read data, second miss held across the walk
        do_refill(10'h012, 16'h8155, 3, 4, 6'd2, 1'b1, 10'h013, 1'b0);
        do_refill(10'h013, 16'hC001, 1, 1, 6'd3, 1'b0, '0, 1'b0);
        for (int i = 4; i < ENTRIES; i++) begin
            do_refill(10'(i * 3), {1'b1, 1'(i & 1), 4'b0, 10'(i * 7)}, 1, 1, 6'(i), 1'b0, '0, 1'b0);
        end
        // 51st valid refill wraps to slot 0
        do_refill(10'h200, 16'h8155, 1, 1, 6'd0, 1'b0, '0, 1'b0);

        // reset in WAIT: outputs clear at once, late rvalid ignored
        e      = '{default: 0};
        e.kind = K_RD;
        e.addr = 16'h012A;
        sb.push_back(e);
        miss_valid = 1'b1;
        miss_vpn   = 10'h02A;
        tick();
        miss_valid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("idx_before_reset", tlb_idx, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_miss_ready", miss_ready, 1);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_tlb_we", tlb_we, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_tlb_idx", tlb_idx, 0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h8077;
        tick();
        mem_rvalid = 1'b0;
        repeat (6) tick();
        chk("idle_after_late_rvalid", miss_ready, 1);
        do_refill(10'h02A, 16'h8077, 1, 1, 6'd0, 1'b0, '0, 1'b0);

`ifdef TLB_DIRTY_WRITEBACK_EN
        // dirty victim vpn 7 / ppn 0x011: write 0x8011 to 0x0107 first
        do_refill(10'h020, 16'h8005, 1, 1, 6'd1, 1'b0, '0, 1'b1);
`endif

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run by 200000, want finish");
        $fatal(1);
    end

endmodule
